fpu_arbiter: RTL



---
 rtl/fpu_arbiter.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/fpu_arbiter.sv
// ---------------------------------------------------------------------------
// fpu_arbiter
//
// Shares one fixed-latency single-precision FPU pipeline between NREQ
// requesters. A round-robin arbiter accepts at most one operation per cycle,
// the granted payload is registered onto the fpu_* inputs, and a tag shift
// register follows each operation through the FPU so the result comes back
// with the ID of the requester that issued it.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   req_valid / req_ready    per-requester handshake (req_ready is one-hot
//                            or zero, combinational from req_valid)
//   req_op/rmode/opa/opb     packed per-requester payloads
//   fpu_op/rmode/opa/opb     registered FPU inputs
//   fpu_out, fpu_* flags     FPU result and status, valid FPU_LAT cycles
//                            after the operands are presented
//   rsp_valid/id/out/flags   response; out/flags are zero when not valid
//   busy                     any operation in flight
//   sticky_flags, sticky_clr per-requester sticky exception flags
//                            {invalid, div_by_zero, overflow, underflow, ine}
//
// Build option: define FPU_ARB_STICKY_EN to implement the sticky flags;
// otherwise sticky_flags reads 0 and sticky_clr is ignored.
// ---------------------------------------------------------------------------
module fpu_arbiter #(
    parameter int NREQ    = 4,
    parameter int IDW     = 2,
    parameter int FPU_LAT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*3-1:0]    req_op,
    input  logic [NREQ*2-1:0]    req_rmode,
    input  logic [NREQ*32-1:0]   req_opa,
    input  logic [NREQ*32-1:0]   req_opb,
    output logic [2:0]           fpu_op,
    output logic [1:0]           fpu_rmode,
    output logic [31:0]          fpu_opa,
    output logic [31:0]          fpu_opb,
    input  logic [31:0]          fpu_out,
    input  logic                 fpu_ine,
    input  logic                 fpu_overflow,
    input  logic                 fpu_underflow,
    input  logic                 fpu_div_by_zero,
    input  logic                 fpu_inf,
    input  logic                 fpu_zero,
    input  logic                 fpu_snan,
    input  logic                 fpu_qnan,
    output logic                 rsp_valid,
    output logic [IDW-1:0]       rsp_id,
    output logic [31:0]          rsp_out,
    output logic [7:0]           rsp_flags,
    output logic                 busy,
    output logic [NREQ*5-1:0]    sticky_flags,
    input  logic [NREQ-1:0]      sticky_clr
);

    // ---------------- round-robin arbitration ----------------
    logic [IDW-1:0] ptr_reg;
    logic [IDW-1:0] ptr_next;
    logic [IDW-1:0] grant_idx;
    logic [IDW-1:0] cand;
    logic           transfer;

    always_comb begin
        grant_idx = '0;
        transfer  = 1'b0;
        cand      = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = IDW'((int'(ptr_reg) + k) % NREQ);
            if (!transfer && req_valid[cand]) begin
                transfer  = 1'b1;
                grant_idx = cand;
            end
        end
        // No grants while in reset, so a requester never believes an
        // operation was accepted that reset is about to discard.
        if (rst) begin
            transfer = 1'b0;
        end
    end

    assign req_ready = transfer ? (NREQ'(1) << grant_idx) : '0;
    assign ptr_next  = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_reg <= '0;
        end else if (transfer) begin
            ptr_reg <= ptr_next;
        end
    end

    // ---------------- issue registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            fpu_op    <= '0;
            fpu_rmode <= '0;
            fpu_opa   <= '0;
            fpu_opb   <= '0;
        end else if (transfer) begin
            fpu_op    <= req_op[int'(grant_idx) * 3 +: 3];
            fpu_rmode <= req_rmode[int'(grant_idx) * 2 +: 2];
            fpu_opa   <= req_opa[int'(grant_idx) * 32 +: 32];
            fpu_opb   <= req_opb[int'(grant_idx) * 32 +: 32];
        end
    end

    // ---------------- tag pipeline ----------------
    // Stage 0 lines up with the fpu_* registers (the cycle the operands are
    // presented); FPU_LAT further stages line up with fpu_out, so the last
    // stage is valid exactly when the FPU result for that tag appears.
    logic           tag_valid_reg [FPU_LAT+1];
    logic [IDW-1:0] tag_id_reg    [FPU_LAT+1];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s <= FPU_LAT; s++) begin
                tag_valid_reg[s] <= 1'b0;
                tag_id_reg[s]    <= '0;
            end
        end else begin
            tag_valid_reg[0] <= transfer;
            tag_id_reg[0]    <= grant_idx;
            for (int s = 1; s <= FPU_LAT; s++) begin
                tag_valid_reg[s] <= tag_valid_reg[s-1];
                tag_id_reg[s]    <= tag_id_reg[s-1];
            end
        end
    end

    always_comb begin
        busy = 1'b0;
        for (int s = 0; s <= FPU_LAT; s++) begin
            busy = busy | tag_valid_reg[s];
        end
    end

    // ---------------- response ----------------
    assign rsp_valid = tag_valid_reg[FPU_LAT];
    assign rsp_id    = tag_id_reg[FPU_LAT];
    assign rsp_out   = rsp_valid ? fpu_out : 32'd0;
    assign rsp_flags = rsp_valid ? {fpu_qnan, fpu_snan, fpu_inf, fpu_zero,
                                    fpu_div_by_zero, fpu_underflow,
                                    fpu_overflow, fpu_ine} : 8'd0;

    // ---------------- sticky flags ----------------
`ifdef FPU_ARB_STICKY_EN
    logic [4:0] new_sticky;
    assign new_sticky = {fpu_snan | fpu_qnan, fpu_div_by_zero, fpu_overflow,
                         fpu_underflow, fpu_ine};

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_sticky
        logic       hit;
        logic [4:0] entry_reg;

        assign hit = rsp_valid && (rsp_id == IDW'(gi));

        // A clear coinciding with a set keeps only the new flags.
        always_ff @(posedge clk) begin
            if (rst) begin
                entry_reg <= '0;
            end else if (sticky_clr[gi]) begin
                entry_reg <= hit ? new_sticky : 5'd0;
            end else if (hit) begin
                entry_reg <= entry_reg | new_sticky;
            end
        end

        assign sticky_flags[gi*5 +: 5] = entry_reg;
    end
`else
    logic unused_sticky_clr;
    assign unused_sticky_clr = ^sticky_clr;
    assign sticky_flags      = '0;
`endif

endmodule
